// File: rtl/multi_cycle_control.sv
// Multi-cycle RV32 control FSM: fetch/decode/execute/mem/writeback
// with memory wait timeout, retire counter and absorbing trap state.
module multi_cycle_control #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_write,
  output logic        alu_src_b,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        illegal,
  output logic        bus_error,
  output logic        halted,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP
  } state_t;

  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_REG  = 7'b0110011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [7:0] WMAX    = 8'(MEM_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic [31:0] retired_q;
  logic        illegal_q, bus_error_q;
  logic        set_ill, set_berr, retire;
  logic        req_c, irw_c, pcw_c, rw_c;
  logic        is_br, is_reg, is_ld, is_st, legal;

  assign is_br  = opcode == OP_BR;
  assign is_reg = opcode == OP_REG;
  assign is_ld  = opcode == OP_LD;
  assign is_st  = opcode == OP_ST;
  assign legal  = is_br | is_reg | is_ld | is_st |
                  opcode == OP_JAL | opcode == OP_JALR |
                  opcode == OP_IMM;

  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    set_ill      = 1'b0;
    set_berr     = 1'b0;
    retire       = 1'b0;
    req_c        = 1'b0;
    irw_c        = 1'b0;
    pcw_c        = 1'b0;
    rw_c         = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    alu_src_b    = 1'b0;
    pc_src       = 2'b00;
    wb_sel       = 2'b00;
    unique case (state_q)
      FETCH: begin
        req_c = 1'b1;
        if (mem_ready) begin
          irw_c   = 1'b1;
          state_d = DECODE;
        end else if (wcnt_q == WMAX) begin
          set_berr = 1'b1;
          state_d  = TRAP;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      DECODE: begin
        if (legal) begin
          state_d = EXECUTE;
        end else begin
          set_ill = 1'b1;
          state_d = TRAP;
        end
      end
      EXECUTE: begin
        alu_src_b = !(is_reg | is_br);
        wcnt_d    = 8'd0;
        if (is_br) begin
          pcw_c   = 1'b1;
          pc_src  = {1'b0, branch_taken};
          retire  = 1'b1;
          state_d = FETCH;
        end else if (is_ld | is_st) begin
          state_d = MEM;
        end else begin
          state_d = WRITEBACK;
        end
      end
      MEM: begin
        req_c        = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = is_st;
        if (mem_ready) begin
          wcnt_d = 8'd0;
          if (is_st) begin
            pcw_c   = 1'b1;
            retire  = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WRITEBACK;
          end
        end else if (wcnt_q == WMAX) begin
          set_berr = 1'b1;
          state_d  = TRAP;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      WRITEBACK: begin
        rw_c    = 1'b1;
        pcw_c   = 1'b1;
        retire  = 1'b1;
        wcnt_d  = 8'd0;
        state_d = FETCH;
        if (is_ld) begin
          wb_sel = 2'b01;
        end else if (opcode == OP_JAL) begin
          wb_sel = 2'b10;
          pc_src = 2'b01;
        end else if (opcode == OP_JALR) begin
          wb_sel = 2'b10;
          pc_src = 2'b10;
        end
      end
      TRAP: ;
      default: state_d = TRAP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FETCH;
      wcnt_q      <= 8'd0;
      retired_q   <= 32'd0;
      illegal_q   <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (retire) retired_q <= retired_q + 32'd1;
      if (set_ill) illegal_q <= 1'b1;
      if (set_berr) bus_error_q <= 1'b1;
    end
  end

  // Strobes are gated by rst_n so they drop the instant reset asserts.
  assign mem_req   = rst_n & req_c;
  assign ir_write  = rst_n & irw_c;
  assign pc_write  = rst_n & pcw_c;
  assign reg_write = rst_n & rw_c;
  assign illegal   = illegal_q;
  assign bus_error = bus_error_q;
  assign halted    = state_q == TRAP;
  assign retired   = retired_q;

endmodule
